// File: rtl/load_store_unit.sv
// Load/store unit: accepts one memory op from execute, checks alignment and
// address range, issues a single-cycle data-memory request and returns the
// load data / store completion (or a RISC-V exception cause) to writeback.

package lsu_pkg;
  typedef enum logic [1:0] {
    BYTE      = 2'b00,
    HALF_WORD = 2'b01,
    WORD      = 2'b10
  } mem_size_t;
endpackage

module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 16,
  parameter int unsigned CAUSE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ex_valid,
  output logic                   ex_ready,
  input  logic                   ex_is_store,
  input  mem_size_t              ex_size,
  input  logic                   ex_unsigned,
  input  logic [31:0]            ex_addr,
  input  logic [31:0]            ex_wdata,
  input  logic [4:0]             ex_rd,
  output logic                   dmem_req,
  output logic                   dmem_wr_en,
  output mem_size_t              dmem_data_size,
  output logic [31:0]            dmem_addr,
  output logic [31:0]            dmem_wr_data,
  output logic                   dmem_zero_extend,
  input  logic [31:0]            dmem_rd_data,
  output logic                   wb_valid,
  input  logic                   wb_ready,
  output logic                   wb_is_load,
  output logic [4:0]             wb_rd,
  output logic [31:0]            wb_data,
  output logic                   exc_valid,
  output logic [CAUSE_WIDTH-1:0] exc_cause,
  output logic [31:0]            exc_addr
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    FAULT
  } state_t;

  localparam logic [CAUSE_WIDTH-1:0] CAUSE_LOAD_MISALIGNED  = CAUSE_WIDTH'(4);
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_LOAD_FAULT       = CAUSE_WIDTH'(5);
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_STORE_MISALIGNED = CAUSE_WIDTH'(6);
  localparam logic [CAUSE_WIDTH-1:0] CAUSE_STORE_FAULT      = CAUSE_WIDTH'(7);

  state_t                 state;
  logic                   is_store_q;
  mem_size_t              size_q;
  logic                   unsigned_q;
  logic [31:0]            addr_q;
  logic [31:0]            wdata_q;
  logic [4:0]             rd_q;
  logic [CAUSE_WIDTH-1:0] cause_q;

  logic                   misaligned;
  logic                   out_of_range;
  logic [CAUSE_WIDTH-1:0] fault_cause;
  logic                   in_access;
  logic                   in_fault;

  // Alignment and range checks on the incoming op; misalignment wins.
  always_comb begin
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    case (ex_size)
      BYTE:      misaligned = 1'b0;
      HALF_WORD: misaligned = ex_addr[0];
      WORD:      misaligned = |ex_addr[1:0];
      default:   out_of_range = 1'b1;
    endcase
    // Shift form stays legal when ADDR_WIDTH covers the full 32 bits.
    if ((ex_addr >> ADDR_WIDTH) != '0) out_of_range = 1'b1;
    if (misaligned)
      fault_cause = ex_is_store ? CAUSE_STORE_MISALIGNED : CAUSE_LOAD_MISALIGNED;
    else
      fault_cause = ex_is_store ? CAUSE_STORE_FAULT : CAUSE_LOAD_FAULT;
  end

  assign in_access = (state == ACCESS);
  assign in_fault  = (state == FAULT);

  // Memory request and exception outputs are decoded from the state register
  // and captured op, so an asynchronous reset drops them immediately.
  assign ex_ready         = (state == IDLE) && !rst;
  assign dmem_req         = in_access;
  assign dmem_wr_en       = in_access && is_store_q;
  assign dmem_data_size   = in_access ? size_q : BYTE;
  assign dmem_addr        = in_access ? addr_q : '0;
  assign dmem_wr_data     = in_access ? wdata_q : '0;
  assign dmem_zero_extend = in_access && unsigned_q;
  assign exc_valid        = in_fault;
  assign exc_cause        = in_fault ? cause_q : '0;
  assign exc_addr         = in_fault ? addr_q : '0;

  // Control FSM: capture op, one access cycle, then hold the completion.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      is_store_q <= 1'b0;
      size_q     <= BYTE;
      unsigned_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      cause_q    <= '0;
      wb_valid   <= 1'b0;
      wb_is_load <= 1'b0;
      wb_rd      <= '0;
      wb_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid && ex_ready) begin
            is_store_q <= ex_is_store;
            size_q     <= ex_size;
            unsigned_q <= ex_unsigned;
            addr_q     <= ex_addr;
            wdata_q    <= ex_wdata;
            rd_q       <= ex_rd;
            cause_q    <= fault_cause;
            state      <= (misaligned || out_of_range) ? FAULT : ACCESS;
          end
        end
        ACCESS: begin
          wb_valid   <= 1'b1;
          wb_is_load <= !is_store_q;
          wb_rd      <= rd_q;
          wb_data    <= is_store_q ? '0 : dmem_rd_data;
          state      <= RESP;
        end
        RESP: begin
          if (wb_ready) begin
            wb_valid   <= 1'b0;
            wb_is_load <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            state      <= IDLE;
          end
        end
        FAULT: begin
          if (wb_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a byte-array data memory answers
// the DUT, and a separate byte-array reference model predicts every result.

module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int unsigned AW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ex_valid = 1'b0;
  logic        ex_ready;
  logic        ex_is_store = 1'b0;
  mem_size_t   ex_size = BYTE;
  logic        ex_unsigned = 1'b0;
  logic [31:0] ex_addr = '0;
  logic [31:0] ex_wdata = '0;
  logic [4:0]  ex_rd = '0;
  logic        dmem_req;
  logic        dmem_wr_en;
  mem_size_t   dmem_data_size;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wr_data;
  logic        dmem_zero_extend;
  logic [31:0] dmem_rd_data;
  logic        wb_valid;
  logic        wb_ready = 1'b0;
  logic        wb_is_load;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_addr;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.ADDR_WIDTH(AW), .CAUSE_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_is_store(ex_is_store),
    .ex_size(ex_size), .ex_unsigned(ex_unsigned), .ex_addr(ex_addr),
    .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .dmem_req(dmem_req), .dmem_wr_en(dmem_wr_en), .dmem_data_size(dmem_data_size),
    .dmem_addr(dmem_addr), .dmem_wr_data(dmem_wr_data),
    .dmem_zero_extend(dmem_zero_extend), .dmem_rd_data(dmem_rd_data),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_is_load(wb_is_load),
    .wb_rd(wb_rd), .wb_data(wb_data),
    .exc_valid(exc_valid), .exc_cause(exc_cause), .exc_addr(exc_addr)
  );

  always #5 clk = ~clk;

  // ---------------- data memory device (environment) ----------------
  logic [7:0]  dev_mem [0:65535];
  logic [15:0] da;
  logic [7:0]  b0, b1, b2, b3;

  initial for (int i = 0; i < 65536; i++) dev_mem[i] <= 8'h00;

  always_comb begin
    da = dmem_addr[15:0];
    b0 = dev_mem[da];
    b1 = dev_mem[da + 16'd1];
    b2 = dev_mem[da + 16'd2];
    b3 = dev_mem[da + 16'd3];
    dmem_rd_data = '0;
    case (dmem_data_size)
      BYTE:      dmem_rd_data = dmem_zero_extend ? {24'h0, b0} : {{24{b0[7]}}, b0};
      HALF_WORD: dmem_rd_data = dmem_zero_extend ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
      WORD:      dmem_rd_data = {b3, b2, b1, b0};
      default:   dmem_rd_data = '0;
    endcase
  end

  always @(posedge clk) begin
    if (dmem_req && dmem_wr_en) begin
      dev_mem[dmem_addr[15:0]] <= dmem_wr_data[7:0];
      if (dmem_data_size != BYTE) dev_mem[dmem_addr[15:0] + 16'd1] <= dmem_wr_data[15:8];
      if (dmem_data_size == WORD) begin
        dev_mem[dmem_addr[15:0] + 16'd2] <= dmem_wr_data[23:16];
        dev_mem[dmem_addr[15:0] + 16'd3] <= dmem_wr_data[31:24];
      end
    end
  end

  // ---------------- reference model ----------------
  byte unsigned model_mem [0:65535];

  function automatic int size_bytes(input logic [1:0] sz);
    return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
  endfunction

  // 0 means the access is legal; otherwise the RISC-V cause number.
  function automatic int model_cause(input logic st, input logic [1:0] sz, input logic [31:0] addr);
    int n;
    bit mis, bad;
    n   = size_bytes(sz);
    mis = (n != 0) && ((longint'(addr) % n) != 0);
    bad = (n == 0) || (longint'(addr) >= (longint'(1) << AW));
    if (mis) return st ? 6 : 4;
    if (bad) return st ? 7 : 5;
    return 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns, input logic [31:0] addr);
    int n;
    longint v;
    n = size_bytes(sz);
    v = 0;
    for (int k = 0; k < n; k++) v += longint'(model_mem[(addr + k) % 65536]) << (8 * k);
    if (!uns && v >= (longint'(1) << (8 * n - 1))) v -= longint'(1) << (8 * n);
    return v[31:0];
  endfunction

  task automatic model_store(input logic [1:0] sz, input logic [31:0] addr, input logic [31:0] wdata);
    for (int k = 0; k < size_bytes(sz); k++)
      model_mem[(addr + k) % 65536] = byte'((wdata >> (8 * k)) & 32'hFF);
  endtask

  // ---------------- transaction driver (observes, never judges) ----------------
  typedef struct {
    logic        ready_at_accept;
    logic        acc_req, acc_we, acc_zx;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata;
    logic        wb_early, req_after;
    logic        exc_v;
    logic [3:0]  cause;
    logic [31:0] exc_addr;
    logic        req_in_fault;
    logic        wb_v, wb_ld;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        both_valid;
    logic        stable;
    logic        ready_low;
    logic        idle_after;
  } obs_t;

  task automatic run_op(input logic st, input logic [1:0] sz, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [4:0] rd, input int hold, output obs_t o);
    ex_valid = 1'b1; ex_is_store = st; ex_size = mem_size_t'(sz);
    ex_unsigned = uns; ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    o.ready_at_accept = ex_ready;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    o.acc_req = dmem_req; o.acc_we = dmem_wr_en; o.acc_zx = dmem_zero_extend;
    o.acc_size = dmem_data_size; o.acc_addr = dmem_addr; o.acc_wdata = dmem_wr_data;
    o.exc_v = exc_valid; o.cause = exc_cause; o.exc_addr = exc_addr;
    o.wb_early = wb_valid; o.req_in_fault = exc_valid && dmem_req;
    o.ready_low = !ex_ready; o.stable = 1'b1; o.req_after = 1'b0;
    o.wb_v = wb_valid; o.wb_ld = wb_is_load; o.wb_rd = wb_rd; o.wb_data = wb_data;
    o.both_valid = wb_valid && exc_valid;
    if (!exc_valid) begin
      @(posedge clk); #1;
      o.wb_v = wb_valid; o.wb_ld = wb_is_load; o.wb_rd = wb_rd; o.wb_data = wb_data;
      o.req_after = dmem_req; o.ready_low &= !ex_ready;
      o.both_valid |= wb_valid && exc_valid;
    end
    for (int i = 0; i < hold; i++) begin
      // Junk op offered while busy must be ignored.
      ex_valid = 1'b1; ex_is_store = 1'b1; ex_size = WORD;
      ex_addr = {16'h0, 14'($urandom), 2'b00}; ex_wdata = $urandom;
      @(posedge clk); #1;
      if (o.exc_v)
        o.stable &= (exc_valid === 1'b1) && (exc_cause === o.cause) && (exc_addr === o.exc_addr) && (dmem_req === 1'b0);
      else
        o.stable &= (wb_valid === o.wb_v) && (wb_data === o.wb_data) && (wb_rd === o.wb_rd) &&
                    (wb_is_load === o.wb_ld) && (dmem_req === 1'b0);
      o.req_in_fault |= o.exc_v && dmem_req;
      o.ready_low &= !ex_ready;
      o.both_valid |= wb_valid && exc_valid;
    end
    ex_valid = 1'b0;
    wb_ready = 1'b1;
    @(posedge clk); #1;
    wb_ready = 1'b0;
    o.idle_after = (ex_ready === 1'b1) && (wb_valid === 1'b0) && (exc_valid === 1'b0) && (dmem_req === 1'b0);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ex_ready !== 1'b0) begin errors++; $display("FAIL reset_ex_ready: got %b, expected 0", ex_ready); end
    checks++; if ({dmem_req, dmem_wr_en, wb_valid, exc_valid} !== 4'b0) begin errors++; $display("FAIL reset_valids: got %b, expected 0000", {dmem_req, dmem_wr_en, wb_valid, exc_valid}); end
    checks++; if ({wb_data, dmem_addr, exc_addr} !== 96'h0) begin errors++; $display("FAIL reset_data: got %h, expected 0", {wb_data, dmem_addr, exc_addr}); end
    rst = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b, expected 1", ex_ready); end
  endtask

  task automatic test_store_load_word();
    obs_t o;
    run_op(1'b1, 2'd2, 1'b0, 32'h100, 32'hDEADBEEF, 5'd3, 0, o);
    model_store(2'd2, 32'h100, 32'hDEADBEEF);
    checks++; if (o.ready_at_accept !== 1'b1) begin errors++; $display("FAIL sw_ready: got %b, expected 1", o.ready_at_accept); end
    checks++; if ({o.acc_req, o.acc_we} !== 2'b11) begin errors++; $display("FAIL sw_access: got %b, expected 11", {o.acc_req, o.acc_we}); end
    checks++; if (o.acc_addr !== 32'h100 || o.acc_wdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sw_addr_data: got %h/%h, expected 00000100/deadbeef", o.acc_addr, o.acc_wdata); end
    checks++; if (o.req_after !== 1'b0) begin errors++; $display("FAIL sw_one_cycle: got %b, expected 0", o.req_after); end
    checks++; if ({o.wb_v, o.wb_ld} !== 2'b10 || o.wb_data !== 32'h0) begin errors++; $display("FAIL sw_completion: got v/ld %b data %h, expected 10 / 0", {o.wb_v, o.wb_ld}, o.wb_data); end
    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd7, 0, o);
    checks++; if (o.wb_early !== 1'b0 || o.wb_v !== 1'b1) begin errors++; $display("FAIL lw_latency: got early %b at2 %b, expected 0 1", o.wb_early, o.wb_v); end
    checks++; if (o.wb_data !== model_load(2'd2, 1'b0, 32'h100)) begin errors++; $display("FAIL lw_data: got %h, expected %h", o.wb_data, model_load(2'd2, 1'b0, 32'h100)); end
    checks++; if (o.wb_ld !== 1'b1 || o.wb_rd !== 5'd7) begin errors++; $display("FAIL lw_tag: got ld %b rd %0d, expected 1 7", o.wb_ld, o.wb_rd); end
  endtask

  task automatic test_byte_extend();
    obs_t o;
    run_op(1'b1, 2'd0, 1'b0, 32'h200, 32'h12345680, 5'd1, 0, o);
    model_store(2'd0, 32'h200, 32'h12345680);
    run_op(1'b0, 2'd0, 1'b0, 32'h200, 32'h0, 5'd9, 0, o);
    checks++; if (o.wb_data !== model_load(2'd0, 1'b0, 32'h200)) begin errors++; $display("FAIL lb_sign: got %h, expected %h", o.wb_data, model_load(2'd0, 1'b0, 32'h200)); end
    checks++; if (o.acc_zx !== 1'b0) begin errors++; $display("FAIL lb_zx: got %b, expected 0", o.acc_zx); end
    run_op(1'b0, 2'd0, 1'b1, 32'h200, 32'h0, 5'd10, 0, o);
    checks++; if (o.wb_data !== model_load(2'd0, 1'b1, 32'h200)) begin errors++; $display("FAIL lbu_zero: got %h, expected %h", o.wb_data, model_load(2'd0, 1'b1, 32'h200)); end
    checks++; if (o.acc_zx !== 1'b1) begin errors++; $display("FAIL lbu_zx: got %b, expected 1", o.acc_zx); end
  endtask

  task automatic test_misaligned();
    obs_t o;
    run_op(1'b0, 2'd2, 1'b0, 32'h102, 32'h0, 5'd2, 2, o);
    checks++; if (o.exc_v !== 1'b1 || o.cause !== 4'(model_cause(1'b0, 2'd2, 32'h102))) begin errors++; $display("FAIL lw_mis_cause: got v %b cause %0d, expected 1 %0d", o.exc_v, o.cause, model_cause(1'b0, 2'd2, 32'h102)); end
    checks++; if (o.exc_addr !== 32'h102) begin errors++; $display("FAIL lw_mis_addr: got %h, expected 00000102", o.exc_addr); end
    checks++; if (o.acc_req !== 1'b0 || o.req_in_fault !== 1'b0) begin errors++; $display("FAIL lw_mis_noreq: got %b/%b, expected 0/0", o.acc_req, o.req_in_fault); end
    checks++; if (o.wb_v !== 1'b0 || o.stable !== 1'b1 || o.idle_after !== 1'b1) begin errors++; $display("FAIL lw_mis_hold: got wb %b stable %b idle %b, expected 0 1 1", o.wb_v, o.stable, o.idle_after); end
    run_op(1'b1, 2'd1, 1'b0, 32'h1001, 32'hFFFF, 5'd2, 0, o);
    checks++; if (o.cause !== 4'd6 || o.acc_req !== 1'b0) begin errors++; $display("FAIL sh_mis_cause: got cause %0d req %b, expected 6 0", o.cause, o.acc_req); end
  endtask

  task automatic test_out_of_range();
    obs_t o;
    run_op(1'b1, 2'd2, 1'b0, 32'h0, 32'h11223344, 5'd1, 0, o);
    model_store(2'd2, 32'h0, 32'h11223344);
    run_op(1'b1, 2'd2, 1'b0, 32'h0001_0000, 32'hCAFEF00D, 5'd1, 1, o);
    checks++; if (o.exc_v !== 1'b1 || o.cause !== 4'd7 || o.acc_req !== 1'b0) begin errors++; $display("FAIL sw_range: got v %b cause %0d req %b, expected 1 7 0", o.exc_v, o.cause, o.acc_req); end
    run_op(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5'd4, 0, o);
    checks++; if (o.wb_data !== model_load(2'd2, 1'b0, 32'h0)) begin errors++; $display("FAIL range_nowrite: got %h, expected %h", o.wb_data, model_load(2'd2, 1'b0, 32'h0)); end
    run_op(1'b0, 2'd1, 1'b0, 32'h0001_0001, 32'h0, 5'd4, 0, o);
    checks++; if (o.cause !== 4'd4) begin errors++; $display("FAIL lh_mis_priority: got %0d, expected 4", o.cause); end
    run_op(1'b0, 2'd3, 1'b0, 32'h40, 32'h0, 5'd4, 0, o);
    checks++; if (o.cause !== 4'd5 || o.acc_req !== 1'b0) begin errors++; $display("FAIL bad_size: got cause %0d req %b, expected 5 0", o.cause, o.acc_req); end
  endtask

  task automatic test_backpressure();
    obs_t o;
    run_op(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 5'd17, 5, o);
    checks++; if (o.stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b, expected 1", o.stable); end
    checks++; if (o.ready_low !== 1'b1) begin errors++; $display("FAIL bp_ready_low: got %b, expected 1", o.ready_low); end
    checks++; if (o.wb_data !== model_load(2'd2, 1'b0, 32'h100) || o.wb_rd !== 5'd17) begin errors++; $display("FAIL bp_data: got %h rd %0d, expected %h rd 17", o.wb_data, o.wb_rd, model_load(2'd2, 1'b0, 32'h100)); end
    checks++; if (o.idle_after !== 1'b1) begin errors++; $display("FAIL bp_idle_after: got %b, expected 1", o.idle_after); end
  endtask

  task automatic test_reset_mid_access();
    obs_t o;
    run_op(1'b1, 2'd2, 1'b0, 32'h300, 32'hA5A5A5A5, 5'd1, 0, o);
    model_store(2'd2, 32'h300, 32'hA5A5A5A5);
    ex_valid = 1'b1; ex_is_store = 1'b1; ex_size = WORD; ex_addr = 32'h300; ex_wdata = 32'h12345678;
    @(posedge clk); #1;
    ex_valid = 1'b0;
    checks++; if (dmem_req !== 1'b1) begin errors++; $display("FAIL rst_mid_in_access: got %b, expected 1", dmem_req); end
    rst = 1'b1;
    #1;
    checks++; if ({ex_ready, dmem_req, dmem_wr_en, wb_valid, exc_valid} !== 5'b0 || dmem_wr_data !== 32'h0) begin errors++; $display("FAIL rst_mid_outputs: got %b %h, expected 00000 0", {ex_ready, dmem_req, dmem_wr_en, wb_valid, exc_valid}, dmem_wr_data); end
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    checks++; if (ex_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_ready: got %b, expected 1", ex_ready); end
    run_op(1'b0, 2'd2, 1'b0, 32'h300, 32'h0, 5'd5, 0, o);
    checks++; if (o.wb_data !== model_load(2'd2, 1'b0, 32'h300)) begin errors++; $display("FAIL rst_mid_nowrite: got %h, expected %h", o.wb_data, model_load(2'd2, 1'b0, 32'h300)); end
  endtask

  task automatic test_random();
    obs_t        o;
    logic        st, uns;
    logic [1:0]  sz;
    logic [31:0] addr, wdata, exp_data;
    logic [4:0]  rd;
    int          cause, hold;
    for (int t = 0; t < 60; t++) begin
      st    = 1'($urandom);
      uns   = 1'($urandom);
      sz    = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      addr  = ($urandom_range(0, 7) == 0) ? ($urandom | 32'h0001_0000) : (32'h400 + $urandom_range(0, 63));
      wdata = $urandom;
      rd    = 5'($urandom);
      hold  = $urandom_range(0, 2);
      cause = model_cause(st, sz, addr);
      exp_data = (cause == 0 && !st) ? model_load(sz, uns, addr) : 32'h0;
      run_op(st, sz, uns, addr, wdata, rd, hold, o);
      if (cause == 0 && st) model_store(sz, addr, wdata);
      checks++; if (o.exc_v !== (cause != 0)) begin errors++; $display("FAIL rand_exc_valid[%0d]: got %b, expected %b", t, o.exc_v, cause != 0); end
      checks++; if (o.both_valid !== 1'b0 || o.idle_after !== 1'b1) begin errors++; $display("FAIL rand_excl_idle[%0d]: got both %b idle %b, expected 0 1", t, o.both_valid, o.idle_after); end
      if (cause != 0) begin
        checks++; if (o.cause !== 4'(cause) || o.exc_addr !== addr) begin errors++; $display("FAIL rand_fault[%0d]: got %0d %h, expected %0d %h", t, o.cause, o.exc_addr, cause, addr); end
        checks++; if (o.acc_req !== 1'b0 || o.req_in_fault !== 1'b0 || o.wb_v !== 1'b0) begin errors++; $display("FAIL rand_fault_quiet[%0d]: got req %b/%b wb %b, expected 0/0 0", t, o.acc_req, o.req_in_fault, o.wb_v); end
      end else begin
        checks++; if ({o.acc_req, o.acc_we, o.acc_zx} !== {1'b1, st, uns} || o.acc_size !== sz || o.acc_addr !== addr) begin errors++; $display("FAIL rand_access[%0d]: got %b %0d %h, expected %b %0d %h", t, {o.acc_req, o.acc_we, o.acc_zx}, o.acc_size, o.acc_addr, {1'b1, st, uns}, sz, addr); end
        checks++; if (st && o.acc_wdata !== wdata) begin errors++; $display("FAIL rand_wdata[%0d]: got %h, expected %h", t, o.acc_wdata, wdata); end
        checks++; if (o.wb_early !== 1'b0 || o.wb_v !== 1'b1 || o.req_after !== 1'b0) begin errors++; $display("FAIL rand_timing[%0d]: got early %b v %b req %b, expected 0 1 0", t, o.wb_early, o.wb_v, o.req_after); end
        checks++; if (o.wb_data !== exp_data || o.wb_ld !== !st || o.wb_rd !== rd) begin errors++; $display("FAIL rand_wb[%0d]: got %h ld %b rd %0d, expected %h ld %b rd %0d", t, o.wb_data, o.wb_ld, o.wb_rd, exp_data, !st, rd); end
      end
      checks++; if (o.stable !== 1'b1 || o.ready_low !== 1'b1) begin errors++; $display("FAIL rand_hold[%0d]: got stable %b ready_low %b, expected 1 1", t, o.stable, o.ready_low); end
    end
  endtask

  initial begin
    for (int i = 0; i < 65536; i++) model_mem[i] = 8'h00;
    test_reset();
    test_store_load_word();
    test_byte_extend();
    test_misaligned();
    test_out_of_range();
    test_backpressure();
    test_reset_mid_access();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the execute stage and data memory.
- Accepts one load/store per handshake from execute and checks alignment and address range.
- Drives the byte-addressed data-memory request for exactly one cycle, then returns the load data or store completion to writeback.
- Misaligned or out-of-range accesses never reach memory; they are reported as RISC-V exception causes instead.

Parameters:
- ADDR_WIDTH, 16, implemented data-memory address bits; addresses with any bit set in [31:ADDR_WIDTH] are out of range.
- CAUSE_WIDTH, 4, width of the exception cause output.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- ex_valid  in  1  execute presents a memory op.
- ex_ready  out  1  LSU can accept an op.
- ex_is_store  in  1  1 = store, 0 = load.
- ex_size  in  mem_size_t  BYTE / HALF_WORD / WORD.
- ex_unsigned  in  1  zero-extend the load (LBU/LHU).
- ex_addr  in  32  effective address.
- ex_wdata  in  32  store data, right-aligned.
- ex_rd  in  5  destination register tag.
- dmem_req  out  1  memory request.
- dmem_wr_en  out  1  write enable.
- dmem_data_size  out  mem_size_t  access size.
- dmem_addr  out  32  byte address.
- dmem_wr_data  out  32  store data.
- dmem_zero_extend  out  1  zero-extend select.
- dmem_rd_data  in  32  combinational, already-extended read data.
- wb_valid  out  1  completion valid.
- wb_ready  in  1  writeback accepts the completion.
- wb_is_load  out  1  completion carries load data.
- wb_rd  out  5  destination tag.
- wb_data  out  32  load result (0 for stores).
- exc_valid  out  1  exception valid (shares the wb_ready handshake).
- exc_cause  out  CAUSE_WIDTH  4 = load misaligned, 5 = load access fault, 6 = store misaligned, 7 = store access fault.
- exc_addr  out  32  faulting address.

Behaviour:
- Reset: clk is the single clock. rst is asynchronous and active-high. While rst is asserted the state is IDLE, every output is 0, and the captured request registers are 0.
- States: IDLE, ACCESS, RESP, FAULT.
- ex_ready = 1 only in IDLE.
- IDLE:
  - On ex_valid && ex_ready, capture is_store, size, unsigned, addr, wdata and rd.
  - Run the checks below on the incoming values (priority order). If either fails, go to FAULT; otherwise go to ACCESS.
- Alignment check:
  - HALF_WORD requires addr[0] = 0.
  - WORD requires addr[1:0] = 0.
  - BYTE is always aligned.
  - Failure selects cause 4 (load) or 6 (store).
- Range check:
  - addr[31:ADDR_WIDTH] must be 0.
  - Any ex_size encoding other than BYTE/HALF_WORD/WORD is also an access fault.
  - Failure selects cause 5 (load) or 7 (store).
  - Misaligned takes priority over access fault.
- ACCESS (exactly 1 cycle):
  - dmem_req = 1.
  - dmem_wr_en = is_store.
  - dmem_data_size, dmem_addr, dmem_wr_data and dmem_zero_extend come from the captured registers.
  - Loads: register dmem_rd_data into wb_data on the closing edge.
  - Stores: memory writes on that same edge; wb_data is set to 0.
  - Next state: RESP.
- Outside ACCESS: all dmem_* outputs are 0. No request is ever issued in FAULT.
- RESP:
  - wb_valid = 1; wb_is_load = !is_store; wb_rd = captured rd.
  - Outputs hold stable until wb_ready, then go to IDLE.
  - wb_valid is sampled by writeback in the same cycle wb_ready is high.
- FAULT:
  - exc_valid = 1 with exc_cause and exc_addr = captured addr.
  - wb_valid = 0.
  - Hold until wb_ready, then go to IDLE.
- Latency and throughput:
  - Accept at edge N, ACCESS in cycle N+1, wb_valid from cycle N+2.
  - Best-case throughput is one op per 3 cycles.
  - ex_* inputs are ignored outside IDLE.
- wb_valid and exc_valid are never both 1.
- Reset mid-operation: the pending op is dropped. If rst is asserted during ACCESS before the edge, no write occurs.

Test Plan:
- SW addr 0x100 data 0xDEADBEEF, then LW 0x100 -> store: one ACCESS cycle with dmem_wr_en=1, then wb_valid with wb_is_load=0. Load: wb_data = 0xDEADBEEF, wb_valid exactly 2 cycles after the accept edge.
- SB 0x200 data 0x80, then LB and LBU at 0x200 -> LB wb_data = 0xFFFFFF80; LBU wb_data = 0x00000080, dmem_zero_extend=1 during ACCESS.
- LW at 0x102 -> exc_valid, exc_cause=4, exc_addr=0x102, dmem_req stays 0 throughout. SH at 0x1001 -> cause 6.
- SW at 0x0001_0000 with ADDR_WIDTH=16 -> cause 7, no memory write (a readback of 0x0000 is unchanged). A misaligned out-of-range LH at 0x0001_0001 -> cause 4.
- LW completion with wb_ready held 0 for 5 cycles -> wb_valid/wb_data/wb_rd stable for all 5 cycles, ex_ready=0 throughout, IDLE the cycle after wb_ready=1.
- rst pulsed during ACCESS of SW 0x300 data 0x12345678 -> all outputs 0 immediately, ex_ready=1 after release, and a subsequent LW 0x300 returns the prior contents.
